// File: rtl/bidir_io_bank.sv
// -----------------------------------------------------------------------------
// bidir_io_bank
//   Bank of IOWidth bidirectional pins.
//   Each pin can be driven push-pull or open-drain from registered requests.
//   Each pin is read back through a 2-flop synchroniser and a stability filter
//   into read_data. Edges on read_data set sticky per-pin flags, and a masked
//   OR of those flags produces a registered interrupt.
//
// Ports
//   clk          sole clock, rising edge
//   reset        asynchronous, active-high; clears all state and floats every pin
//   oe           per-pin output enable request
//   opendrain    per-pin mode: 1 = open-drain, 0 = push-pull
//   out_data     per-pin output value request
//   ioport       device pins (inout)
//   read_data    synchronised, glitch-filtered pin state
//   rise_flag    sticky rising-edge flags on read_data
//   fall_flag    sticky falling-edge flags on read_data
//   clear_flags  per-pin strobe that clears both flags of that pin
//   irq_mask     per-pin interrupt enable
//   irq          registered OR of (rise_flag | fall_flag) & irq_mask
// -----------------------------------------------------------------------------
module bidir_io_bank #(
  parameter int IOWidth   = 36,
  parameter int FilterLen = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IOWidth-1:0] oe,
  input  logic [IOWidth-1:0] opendrain,
  input  logic [IOWidth-1:0] out_data,
  inout  wire  [IOWidth-1:0] ioport,
  output logic [IOWidth-1:0] read_data,
  output logic [IOWidth-1:0] rise_flag,
  output logic [IOWidth-1:0] fall_flag,
  input  logic [IOWidth-1:0] clear_flags,
  input  logic [IOWidth-1:0] irq_mask,
  output logic               irq
);

  localparam int              CntW    = $clog2(FilterLen + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(FilterLen - 1);

  logic [IOWidth-1:0] oe_p0;
  logic [IOWidth-1:0] od_p0;
  logic [IOWidth-1:0] out_p0;
  logic [IOWidth-1:0] drive_en;
  logic [IOWidth-1:0] drive_val;
  logic [IOWidth-1:0] sync1_p1;
  logic [IOWidth-1:0] sync2_p2;
  logic [CntW-1:0]    cnt [IOWidth];
  logic [IOWidth-1:0] upd;
  logic [IOWidth-1:0] rise_set;
  logic [IOWidth-1:0] fall_set;

  // ---- stage p0: registered drive requests --------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oe_p0  <= '0;
      od_p0  <= '0;
      out_p0 <= '0;
    end else begin
      oe_p0  <= oe;
      od_p0  <= opendrain;
      out_p0 <= out_data;
    end
  end

  // Open-drain pins only ever pull low; a '1' request releases the pin.
  assign drive_en  = oe_p0 & (~od_p0 | ~out_p0);
  assign drive_val = out_p0 & ~od_p0;

  for (genvar i = 0; i < IOWidth; i++) begin : g_pad
    assign ioport[i] = drive_en[i] ? drive_val[i] : 1'bz;
  end

  // ---- stages p1/p2: two-flop synchroniser on the pin level ---------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_p1 <= '0;
      sync2_p2 <= '0;
    end else begin
      sync1_p1 <= ioport;
      sync2_p2 <= sync1_p1;
    end
  end

  // A pin commits when its synchronised level has differed from read_data
  // for FilterLen consecutive samples; any agreeing sample restarts the count.
  always_comb begin
    upd = '0;
    for (int i = 0; i < IOWidth; i++) begin
      upd[i] = (sync2_p2[i] != read_data[i]) && (cnt[i] == CntLast);
    end
  end

  assign rise_set = upd & sync2_p2;
  assign fall_set = upd & ~sync2_p2;

  // ---- filter stage: stability counters -----------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < IOWidth; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < IOWidth; i++) begin
        if ((sync2_p2[i] == read_data[i]) || upd[i]) cnt[i] <= '0;
        else                                         cnt[i] <= cnt[i] + CntW'(1);
      end
    end
  end

  // ---- output stage: filtered level, sticky flags, interrupt --------------
  // A flag set on the same edge as its clear strobe stays set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data <= '0;
      rise_flag <= '0;
      fall_flag <= '0;
      irq       <= 1'b0;
    end else begin
      read_data <= (read_data & ~upd) | (sync2_p2 & upd);
      rise_flag <= rise_set | (rise_flag & ~clear_flags);
      fall_flag <= fall_set | (fall_flag & ~clear_flags);
      irq       <= |((rise_flag | fall_flag) & irq_mask);
    end
  end

endmodule

// File: tb/tb_bidir_io_bank.sv
module tb_bidir_io_bank;

  localparam int W   = 36;
  localparam int FL  = 4;
  localparam int LAT = 2 + FL;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] oe, opendrain, out_data, clear_flags, irq_mask;
  logic [W-1:0] read_data, rise_flag, fall_flag;
  logic         irq;
  logic [W-1:0] tb_en, tb_val;
  tri1  [W-1:0] pins;

  for (genvar g = 0; g < W; g++) begin : g_drv
    assign pins[g] = tb_en[g] ? tb_val[g] : 1'bz;
  end

  always #5 clk = ~clk;

  bidir_io_bank #(.IOWidth(W), .FilterLen(FL)) dut (
    .clk        (clk),
    .reset      (reset),
    .oe         (oe),
    .opendrain  (opendrain),
    .out_data   (out_data),
    .ioport     (pins),
    .read_data  (read_data),
    .rise_flag  (rise_flag),
    .fall_flag  (fall_flag),
    .clear_flags(clear_flags),
    .irq_mask   (irq_mask),
    .irq        (irq)
  );

  typedef struct {
    int           due;
    int           id;
    logic [W-1:0] rd;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         irq;
  } exp_t;

  typedef struct {
    int   pin;
    int   len;
    logic acc;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[5];
  int   cyc;
  int   n_cmp;
  int   n_bad;

  task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int due, input int id, input logic [W-1:0] rd,
                      input logic [W-1:0] rise, input logic [W-1:0] fall, input logic irq_e);
    exp_t e;
    e.due  = due;
    e.id   = id;
    e.rd   = rd;
    e.rise = rise;
    e.fall = fall;
    e.irq  = irq_e;
    sb.push_back(e);
  endtask

  // Advance one clock, sample 1 time unit after the edge, retire due expectations.
  task automatic step();
    int k;
    @(posedge clk);
    #1;
    cyc++;
    k = 0;
    while (k < sb.size()) begin
      if (sb[k].due == cyc) begin
        cmp($sformatf("v%0d_read_data@%0d", sb[k].id, cyc), read_data, sb[k].rd);
        cmp($sformatf("v%0d_rise_flag@%0d", sb[k].id, cyc), rise_flag, sb[k].rise);
        cmp($sformatf("v%0d_fall_flag@%0d", sb[k].id, cyc), fall_flag, sb[k].fall);
        cmp($sformatf("v%0d_irq@%0d", sb[k].id, cyc), W'(irq), W'(sb[k].irq));
        sb.delete(k);
      end else begin
        k++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] m;
    int           c;
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;

    // pin, pulse length in cycles, expected to pass the filter
    vecs[0] = '{pin: 0,  len: 20, acc: 1'b1};
    vecs[1] = '{pin: 5,  len: 3,  acc: 1'b0};
    vecs[2] = '{pin: 9,  len: 4,  acc: 1'b1};
    vecs[3] = '{pin: 35, len: 1,  acc: 1'b0};
    vecs[4] = '{pin: 12, len: 5,  acc: 1'b1};

    reset       = 1'b1;
    oe          = '0;
    opendrain   = '0;
    out_data    = '0;
    clear_flags = '0;
    irq_mask    = '0;
    tb_en       = '1;
    tb_val      = '0;
    #1;
    cmp("reset_read_data", read_data, '0);
    cmp("reset_rise_flag", rise_flag, '0);
    cmp("reset_fall_flag", fall_flag, '0);
    cmp("reset_irq", W'(irq), '0);
    step();
    step();
    reset = 1'b0;
    step();
    step();

    // Table-driven pulses: expectations go on the scoreboard as stimulus is driven.
    for (int v = 0; v < 5; v++) begin
      m        = '0;
      m[vecs[v].pin] = 1'b1;
      irq_mask = m;
      c        = cyc;
      tb_val[vecs[v].pin] = 1'b1;
      push(c + LAT - 1, v, '0, '0, '0, 1'b0);
      push(c + LAT, v, vecs[v].acc ? m : '0, vecs[v].acc ? m : '0, '0, 1'b0);
      push(c + LAT + 1, v, vecs[v].acc ? m : '0, vecs[v].acc ? m : '0, '0, vecs[v].acc);
      push(c + vecs[v].len + LAT - 1, v, vecs[v].acc ? m : '0, vecs[v].acc ? m : '0, '0, vecs[v].acc);
      push(c + vecs[v].len + LAT, v, '0, vecs[v].acc ? m : '0, vecs[v].acc ? m : '0, vecs[v].acc);
      repeat (vecs[v].len) step();
      tb_val[vecs[v].pin] = 1'b0;
      repeat (LAT + 4) step();
      clear_flags = '1;
      step();
      clear_flags = '0;
      step();
      step();
    end
    cmp("scoreboard_drained", W'(sb.size()), '0);

    // Rising flag on pin 7, then clear strobe on the very edge the fall is recorded.
    irq_mask  = '0;
    tb_val[7] = 1'b1;
    repeat (LAT) step();
    cmp("p7_rise_set", W'(rise_flag[7]), W'(1));
    tb_val[7] = 1'b0;
    repeat (LAT - 1) step();
    cmp("p7_fall_not_yet", W'(fall_flag[7]), W'(0));
    clear_flags[7] = 1'b1;
    step();
    clear_flags[7] = 1'b0;
    cmp("p7_rise_cleared", W'(rise_flag[7]), W'(0));
    cmp("p7_fall_wins", W'(fall_flag[7]), W'(1));
    cmp("p7_irq_masked", W'(irq), W'(0));
    irq_mask[7] = 1'b1;
    #0;
    cmp("p7_irq_before_edge", W'(irq), W'(0));
    step();
    cmp("p7_irq_after_mask", W'(irq), W'(1));
    clear_flags = '1;
    step();
    clear_flags = '0;
    irq_mask    = '0;
    step();

    // Open-drain pin 2 and push-pull pin 3, released by the bench onto the pull-up.
    tb_en[2] = 1'b0;
    tb_en[3] = 1'b0;
    #0;
    cmp("pins_pulled_up", W'(pins[3:2]), W'(2'b11));
    repeat (LAT) step();
    cmp("p2_pullup_read", W'(read_data[2]), W'(1));
    oe[2] = 1'b1; opendrain[2] = 1'b1; out_data[2] = 1'b0;
    oe[3] = 1'b1; opendrain[3] = 1'b0; out_data[3] = 1'b1;
    #0;
    cmp("p2_not_driven_before_edge", W'(pins[2]), W'(1));
    step();
    cmp("p2_od_drives_low", W'(pins[2]), W'(0));
    cmp("p3_pp_drives_high", W'(pins[3]), W'(1));
    repeat (LAT - 1) step();
    cmp("p2_read_not_yet", W'(read_data[2]), W'(1));
    step();
    cmp("p2_readback_low", W'(read_data[2]), W'(0));
    cmp("p3_readback_high", W'(read_data[3]), W'(1));
    cmp("p2_fall_flag", W'(fall_flag[2]), W'(1));
    out_data[2] = 1'b1;
    step();
    cmp("p2_od_releases", W'(pins[2]), W'(1));
    repeat (LAT - 1) step();
    cmp("p2_release_not_yet", W'(read_data[2]), W'(0));
    step();
    cmp("p2_release_read", W'(read_data[2]), W'(1));

    // Asynchronous reset with pins driven low and flags set.
    out_data[2] = 1'b0;
    out_data[3] = 1'b0;
    irq_mask    = '1;
    step();
    cmp("pins_driven_low", W'(pins[3:2]), W'(2'b00));
    step();
    cmp("irq_before_reset", W'(irq), W'(1));
    #2;
    reset = 1'b1;
    #1;
    cmp("async_pins_z", W'(pins[3:2]), W'(2'b11));
    cmp("async_read_data", read_data, '0);
    cmp("async_rise_flag", rise_flag, '0);
    cmp("async_fall_flag", fall_flag, '0);
    cmp("async_irq", W'(irq), W'(0));
    oe        = '0;
    opendrain = '0;
    out_data  = '0;
    irq_mask  = '0;
    tb_en     = '1;
    tb_val    = '0;
    step();
    reset = 1'b0;
    step();

    // Reset in the middle of a filter count; the count must restart from zero.
    tb_val[10] = 1'b1;
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (LAT - 1) step();
    cmp("p10_partial_discarded", W'(read_data[10]), W'(0));
    step();
    cmp("p10_read_after_restart", W'(read_data[10]), W'(1));
    cmp("p10_rise_after_restart", W'(rise_flag[10]), W'(1));
    cmp("p10_others_quiet", read_data & ~(W'(1) << 10), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bidir_io_bank.md
BIDIR_IO_BANK -- requirements
Module: bidir_io_bank

Interface
REQ-001 SHALL have parameter IOWidth, default 36, number of pins.
REQ-002 SHALL have parameter FilterLen, default 4, range 1..255, consecutive stable cycles required before a filtered input changes.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 oe  input  IOWidth  per-pin output enable request.
REQ-006 opendrain  input  IOWidth  per-pin mode: 1 = open-drain, 0 = push-pull.
REQ-007 out_data  input  IOWidth  per-pin output value request.
REQ-008 ioport  inout  IOWidth  device pins.
REQ-009 read_data  output  IOWidth  synchronised, glitch-filtered pin state.
REQ-010 rise_flag  output  IOWidth  sticky rising-edge flags on read_data.
REQ-011 fall_flag  output  IOWidth  sticky falling-edge flags on read_data.
REQ-012 clear_flags  input  IOWidth  per-pin one-cycle strobe clearing both flags.
REQ-013 irq_mask  input  IOWidth  per-pin interrupt enable.
REQ-014 irq  output  1  OR of (rise_flag | fall_flag) & irq_mask.

Function
REQ-015 oe, opendrain, out_data SHALL be registered; pin drive SHALL reflect inputs one cycle after sampling.
REQ-016 Push-pull pin: registered oe=1 drives registered out_data; oe=0 drives Z.
REQ-017 Open-drain pin: drives 0 only when registered oe=1 and out_data=0; otherwise Z.
REQ-018 Each pin SHALL pass through a 2-flop synchroniser (s1, s2) before filtering.
REQ-019 Each pin SHALL have a filter counter of width clog2(FilterLen+1); s2 == read_data -> counter cleared to 0.
REQ-020 s2 != read_data and counter < FilterLen-1 -> counter increments.
REQ-021 s2 != read_data and counter == FilterLen-1 -> read_data[i] <= s2, counter <= 0.
REQ-022 Pin-to-read_data latency for a stable change SHALL be exactly 2+FilterLen clock edges; pulses shorter than FilterLen cycles at s2 SHALL be rejected.
REQ-023 read_data 0->1 SHALL set rise_flag[i] on the same edge read_data updates; 1->0 SHALL set fall_flag[i] likewise.
REQ-024 Flags SHALL hold until clear_flags[i] is sampled high; set and clear in the same cycle -> set wins.
REQ-025 irq SHALL be registered, asserting one cycle after the qualifying flag asserts or the mask bit is set.
REQ-026 Pins are independent; no pin's state SHALL affect another's.
REQ-027 Driven pins SHALL read back their own driven value through the same sync/filter path.

Reset
REQ-028 reset asserted SHALL immediately (asynchronously) clear all output/oe registers (all pins Z), s1, s2, counters, read_data, rise_flag, fall_flag, irq to 0.
REQ-029 Reset mid-filter SHALL discard partial counts; after release filtering restarts from counter 0.
REQ-030 A pin high at reset release SHALL produce read_data=1 and rise_flag=1 after 2+FilterLen edges (defined startup behaviour).

Verification
REQ-031 FilterLen=4, pin 0 input 0->1 held -> read_data[0]=1 and rise_flag[0]=1 exactly 6 edges later; irq=1 one edge after if irq_mask[0]=1.
REQ-032 FilterLen=4, 3-cycle high glitch on pin 5 -> read_data[5] stays 0, no flags, irq stays 0.
REQ-033 opendrain[2]=1, oe[2]=1: out_data[2]=0 -> pin driven 0; out_data[2]=1 -> pin Z (pull-up reads 1 after 6 edges); push-pull pin 3 oe=1 out_data=1 -> driven 1.
REQ-034 rise_flag[7] set, clear_flags[7] pulsed in the cycle a new fall sets fall_flag[7] -> rise_flag[7]=0, fall_flag[7]=1.
REQ-035 reset asserted mid-operation with pins driven and flags set -> all pins Z, read_data=0, flags=0, irq=0 without waiting for a clock edge.
